// File: rtl/delay_config_ctrl_pkg.sv
// Shared constants, width helpers and FSM encoding for the delay index
// configuration block and its serial frame receiver.
package delay_config_ctrl_pkg;

  localparam int NUMBER_OF_BITS = 16;
  localparam int BUFFER_SIZE    = 8;
  localparam int SEL_W          = 3;

  function automatic int idx_w(input int buf_size);
    return (buf_size > 1) ? $clog2(buf_size) : 1;
  endfunction

  function automatic int frame_len(input int buf_size);
    return SEL_W + idx_w(buf_size) + 1;
  endfunction

  localparam int IDX_W     = idx_w(BUFFER_SIZE);
  localparam int FRAME_LEN = frame_len(BUFFER_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } rx_state_e;

endpackage

// File: rtl/delay_config_ctrl_cfg_frame_rx.sv
// Serial config frame receiver: shifts in select/value/parity MSB first,
// validates the frame and emits a one-cycle write strobe or an error pulse.
module cfg_frame_rx
  import delay_config_ctrl_pkg::*;
#(
  parameter int  NUM_DELAYS  = 8,
  parameter int  BUFFER_SIZE = 8,
  localparam int IDX_W       = idx_w(BUFFER_SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic             cfg_data,
  output logic             cfg_busy,
  output logic             wr_en,
  output logic [SEL_W-1:0] wr_sel,
  output logic [IDX_W-1:0] wr_val,
  output logic             err_parity,
  output logic             err_range,
  output logic             err_abort
);

  localparam int FRAME_LEN = frame_len(BUFFER_SIZE);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  rx_state_e              state;
  rx_state_e              state_nxt;
  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_LEN-1:0]   frame;
  logic                   en_low_seen;
  logic                   abort_q;
  logic                   start;
  logic                   frame_done;
  logic                   parity_bad;
  logic                   range_bad;

  // A frame only starts after cfg_en has been seen low, so a level held
  // across CHECK or across reset release cannot begin a spurious frame.
  assign start      = cfg_en && en_low_seen;
  assign frame_done = cfg_en && (bit_cnt == CNT_W'(FRAME_LEN - 1));

  assign wr_sel     = frame[FRAME_LEN-1 -: SEL_W];
  assign wr_val     = frame[1 +: IDX_W];
  assign parity_bad = ^frame;
  assign range_bad  = (int'(wr_sel) >= NUM_DELAYS) || (int'(wr_val) >= BUFFER_SIZE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!cfg_en)         state_nxt = ST_IDLE;
        else if (frame_done) state_nxt = ST_CHECK;
      end
      ST_CHECK: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      frame       <= '0;
      en_low_seen <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      abort_q <= (state == ST_SHIFT) && !cfg_en;
      if (!cfg_en) begin
        en_low_seen <= 1'b1;
      end else if ((state == ST_IDLE) && start) begin
        en_low_seen <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            frame   <= {{(FRAME_LEN-1){1'b0}}, cfg_data};
            bit_cnt <= CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (cfg_en) begin
            frame   <= {frame[FRAME_LEN-2:0], cfg_data};
            bit_cnt <= bit_cnt + CNT_W'(1);
          end else begin
            frame   <= '0;
            bit_cnt <= '0;
          end
        end
        default: begin
          frame   <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  // Parity outranks range so each frame yields at most one error pulse.
  always_comb begin
    cfg_busy   = (state != ST_IDLE);
    wr_en      = 1'b0;
    err_parity = 1'b0;
    err_range  = 1'b0;
    err_abort  = abort_q;
    if (state == ST_CHECK) begin
      if (parity_bad)     err_parity = 1'b1;
      else if (range_bad) err_range  = 1'b1;
      else                wr_en      = 1'b1;
    end
  end

endmodule

// File: rtl/delay_config_ctrl.sv
// Delay index configuration: shadow registers written by serial frames,
// copied to the active set on a word-select rising edge.
module delay_config_ctrl
  import delay_config_ctrl_pkg::*;
#(
  parameter int  NUM_DELAYS  = 8,
  parameter int  BUFFER_SIZE = 8,
  localparam int IDX_W       = idx_w(BUFFER_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ws,
  input  logic                        cfg_en,
  input  logic                        cfg_data,
  output logic [NUM_DELAYS*IDX_W-1:0] delay_index,
  output logic                        cfg_busy,
  output logic                        pending,
  output logic                        commit,
  output logic                        err_parity,
  output logic                        err_range,
  output logic                        err_abort
);

  logic             ws_q;
  logic             ws_rise;
  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;
  logic [IDX_W-1:0] wr_val;
  logic [IDX_W-1:0] shadow [NUM_DELAYS];
  logic [IDX_W-1:0] active [NUM_DELAYS];

  cfg_frame_rx #(
    .NUM_DELAYS  (NUM_DELAYS),
    .BUFFER_SIZE (BUFFER_SIZE)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_en     (cfg_en),
    .cfg_data   (cfg_data),
    .cfg_busy   (cfg_busy),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_val     (wr_val),
    .err_parity (err_parity),
    .err_range  (err_range),
    .err_abort  (err_abort)
  );

  assign ws_rise = ws && !ws_q;

  // A write landing on the same edge as a commit stays pending: the copy
  // below samples the old shadow contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_q    <= 1'b0;
      pending <= 1'b0;
      commit  <= 1'b0;
    end else begin
      ws_q   <= ws;
      commit <= ws_rise && pending;
      if (wr_en) begin
        pending <= 1'b1;
      end else if (ws_rise) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DELAYS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_DELAYS; k++) begin
        if (wr_en && (wr_sel == SEL_W'(k))) shadow[k] <= wr_val;
        if (ws_rise && pending)             active[k] <= shadow[k];
      end
    end
  end

  for (genvar g = 0; g < NUM_DELAYS; g++) begin : g_idx
    assign delay_index[g*IDX_W +: IDX_W] = active[g];
  end

endmodule

// File: tb/tb_delay_config_ctrl.sv
// Directed bench for delay_config_ctrl with a commit scoreboard.
module tb_delay_config_ctrl;

  localparam int ND = 6;
  localparam int BS = 8;
  localparam int IW = 3;
  localparam int FL = 7;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ws;
  logic           cfg_en;
  logic           cfg_data;
  logic [ND*IW-1:0] delay_index;
  logic           cfg_busy;
  logic           pending;
  logic           commit;
  logic           err_parity;
  logic           err_range;
  logic           err_abort;

  int checks = 0;
  int errors = 0;
  int n_par  = 0;
  int n_rng  = 0;
  int n_abt  = 0;
  int n_com  = 0;
  logic [ND*IW-1:0] exp_q [$];
  logic [ND*IW-1:0] exp_v;

  always #5 clk = ~clk;

  delay_config_ctrl #(
    .NUM_DELAYS  (ND),
    .BUFFER_SIZE (BS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ws          (ws),
    .cfg_en      (cfg_en),
    .cfg_data    (cfg_data),
    .delay_index (delay_index),
    .cfg_busy    (cfg_busy),
    .pending     (pending),
    .commit      (commit),
    .err_parity  (err_parity),
    .err_range   (err_range),
    .err_abort   (err_abort)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse counters and commit scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_parity) n_par++;
      if (err_range)  n_rng++;
      if (err_abort)  n_abt++;
      if (commit) begin
        n_com++;
        chk("commit_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          chk("commit_index", 32'(delay_index), 32'(exp_v));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [2:0] sel, input logic [2:0] val,
                            input bit flip, input int nbits, input bit ws_at_check);
    logic [6:0] f;
    f = {sel, val, (^{sel, val}) ^ flip};
    for (int i = 0; i < nbits; i++) begin
      cfg_en   = 1'b1;
      cfg_data = f[6-i];
      tick();
      if (i == 1) chk("busy_in_frame", 32'(cfg_busy), 32'd1);
    end
    if (ws_at_check) ws = 1'b1;
    cfg_en   = 1'b0;
    cfg_data = 1'b0;
    tick();
  endtask

  task automatic ws_pulse();
    ws = 1'b1;
    tick();
    ws = 1'b0;
    tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    ws       = 1'b0;
    cfg_en   = 1'b0;
    cfg_data = 1'b0;
    #12;
    chk("rst_index",   32'(delay_index), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_busy",    32'(cfg_busy), 32'd0);
    chk("rst_pulses",  32'({commit, err_parity, err_range, err_abort}), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Good frame then commit
    send_frame(3'd2, 3'd5, 1'b0, FL, 1'b0);
    chk("good_pending", 32'(pending), 32'd1);
    chk("good_no_early_update", 32'(delay_index), 32'd0);
    exp_q.push_back(18'd320);
    ws_pulse();
    chk("good_commit_cnt", n_com, 32'd1);
    chk("good_pending_clr", 32'(pending), 32'd0);
    chk("good_index", 32'(delay_index), 32'd320);

    // Bad parity
    send_frame(3'd1, 3'd3, 1'b1, FL, 1'b0);
    chk("par_cnt", n_par, 32'd1);
    chk("par_pending", 32'(pending), 32'd0);
    ws_pulse();
    chk("par_no_commit", n_com, 32'd1);
    chk("par_index", 32'(delay_index), 32'd320);

    // Abort after 4 bits
    send_frame(3'd3, 3'd6, 1'b0, 4, 1'b0);
    chk("abt_cnt", n_abt, 32'd1);
    chk("abt_idle", 32'(cfg_busy), 32'd0);
    chk("abt_pending", 32'(pending), 32'd0);

    // Write coinciding with a ws rise
    send_frame(3'd0, 3'd7, 1'b0, FL, 1'b0);
    chk("same_pending0", 32'(pending), 32'd1);
    exp_q.push_back(18'd327);
    send_frame(3'd1, 3'd4, 1'b0, FL, 1'b1);
    ws = 1'b0;
    tick();
    chk("same_commit_cnt", n_com, 32'd2);
    chk("same_pending_kept", 32'(pending), 32'd1);
    chk("same_index", 32'(delay_index), 32'd327);
    exp_q.push_back(18'd359);
    ws_pulse();
    chk("same_commit_cnt2", n_com, 32'd3);
    chk("same_pending_clr", 32'(pending), 32'd0);

    // Select out of range
    send_frame(3'd7, 3'd1, 1'b0, FL, 1'b0);
    chk("rng_cnt", n_rng, 32'd1);
    chk("rng_par_cnt", n_par, 32'd1);
    chk("rng_pending", 32'(pending), 32'd0);

    // Async reset mid-frame
    send_frame(3'd0, 3'd4, 1'b0, FL, 1'b0);
    exp_q.push_back(18'd356);
    ws_pulse();
    chk("pre_rst_index", 32'(delay_index), 32'd356);
    for (int i = 0; i < 3; i++) begin
      cfg_en   = 1'b1;
      cfg_data = i[0];
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_index",   32'(delay_index), 32'd0);
    chk("arst_busy",    32'(cfg_busy), 32'd0);
    chk("arst_pending", 32'(pending), 32'd0);
    chk("arst_pulses",  32'({commit, err_parity, err_range, err_abort}), 32'd0);
    cfg_en = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("arst_no_abort", n_abt, 32'd1);
    send_frame(3'd3, 3'd2, 1'b0, FL, 1'b0);
    chk("post_rst_pending", 32'(pending), 32'd1);
    exp_q.push_back(18'd1024);
    ws_pulse();
    chk("post_rst_commit_cnt", n_com, 32'd5);
    chk("post_rst_index", 32'(delay_index), 32'd1024);
    chk("err_totals", 32'(n_par + n_rng + n_abt), 32'd3);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
